csa_acc_ctrl: RTL and testbench
===============================

Name: csa_acc_ctrl

Overview:
Sequencer that drives a WIDTH-bit carry-save adder stage as a multi-operand accumulator. It accepts a programmed count of operands over a valid/ready stream and compresses each one into redundant sum/carry registers with the CSA equations (Sum = A^B^Cin, Cout = majority). It then resolves the redundant pair to a binary result by iterating the CSA with a zero third input. It sits between an operand source and a result consumer in the adder datapath.

Parameters:
WIDTH, 4, operand width in bits
MAX_OPS, 16, maximum operands per job (>=1)
NOPS_W, derived = $clog2(MAX_OPS+1), width of num_ops (localparam)
ACC_W, derived = WIDTH + $clog2(MAX_OPS), accumulator/result width (localparam)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  job request, sampled only in IDLE
num_ops  input  NOPS_W  operand count for the job, sampled with start
busy  output  1  high in every state except IDLE
op_valid  input  1  operand available
op_data  input  WIDTH  operand, zero-extended to ACC_W
op_ready  output  1  high only in ACCUM
res_valid  output  1  result available (registered)
res_data  output  ACC_W  binary result (registered)
res_ready  input  1  consumer accepts result
err  output  1  sticky illegal-count flag (registered)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; S=0, C=0, remaining=0; busy=0, op_ready=0, res_valid=0, res_data=0, err=0. Reset mid-job discards partial sums; no result is produced.
- States: IDLE, ACCUM, RESOLVE, DONE.
- IDLE, start=1, 1<=num_ops<=MAX_OPS: latch remaining=num_ops, clear S and C, err<=0, go to ACCUM.
- IDLE, start=1, num_ops=0 or num_ops>MAX_OPS: err<=1, stay in IDLE.
- start is ignored outside IDLE. err holds until the next legal start.
- ACCUM: op_ready=1. An operand transfers on op_valid && op_ready. On each transfer:
  - S <= S ^ C ^ X
  - C <= {maj(S,C,X)[ACC_W-2:0], 1'b0}
  - remaining <= remaining-1
- ACCUM exit: on the transfer that takes remaining to 0, go to RESOLVE next cycle. op_valid gaps are allowed; no timeout.
- Outside ACCUM, op_valid and op_data are ignored.
- Width: C is stored pre-shifted, so S+C always equals the running sum. ACC_W guarantees no overflow at MAX_OPS operands of all-ones; the dropped MSB carry is always 0.
- RESOLVE, each cycle:
  - If C==0: res_data<=S, res_valid<=1, go to DONE.
  - Else: S<=S^C, C<={(S&C)[ACC_W-2:0],1'b0}.
  - Terminates in at most ACC_W+1 cycles.
  - If C==0 on entry, RESOLVE lasts exactly 1 cycle: res_valid rises 2 edges after the last operand transfer.
- DONE: res_valid=1, with res_data stable until res_valid && res_ready, then res_valid<=0 and go to IDLE. res_data keeps its value until the next result is written.
- busy: asserted in ACCUM, RESOLVE and DONE; deasserts on the edge of the result handshake.
- Simultaneous events: res_ready with start in the same DONE cycle completes the handshake only; start is not taken until IDLE.

Optional Feature:
Macro CSA_FAST_RESOLVE_EN.
- Defined: RESOLVE always lasts exactly 1 cycle with res_data <= S + C (one carry-propagate adder). res_valid rises 2 edges after the last transfer.
- Undefined: iterative CSA resolve as specified above; no carry-propagate adder is instantiated.
- Results are identical in both builds; only latency differs.

Test Plan:
1. WIDTH=4, MAX_OPS=16: start with num_ops=1, op 4'b1011 -> res_data=8'd11, RESOLVE 1 cycle, res_valid 2 edges after transfer, busy=0 after handshake.
2. num_ops=3, ops 1011, 0010, 0010 -> after op2 S=1001, C=0100; after op3 S=1111, C=0000; res_data=8'd15.
3. num_ops=16, all ops 4'hF with random op_valid gaps -> res_data=8'hF0; RESOLVE <=9 cycles (exactly 1 with CSA_FAST_RESOLVE_EN); compare against a behavioural sum.
4. num_ops=2, ops 4'hF and 4'h1 (carry ripple) -> res_data=8'h10; multi-cycle RESOLVE without the macro, 1 cycle with it.
5. Backpressure: res_ready=0 for 5 cycles with start pulses and op_valid=1 -> res_valid and res_data stable, busy=1, op_ready=0, no new job starts.
6. num_ops=0, then num_ops=17 -> err=1, busy=0, op_ready=0. Then a legal start clears err. rst_n low after 2 of 4 operands -> all outputs 0 immediately; a new job with num_ops=1, op 4'h7 -> res_data=7.

Source files
------------

// File: rtl/csa_acc_ctrl.sv
// Multi-operand accumulator sequencer around a single shared carry-save adder stage.
// Define CSA_FAST_RESOLVE_EN to resolve S/C with one carry-propagate add instead of iterating the CSA.
module csa_acc_ctrl #(
    parameter int WIDTH   = 4,
    parameter int MAX_OPS = 16,
    localparam int NOPS_W = $clog2(MAX_OPS + 1),
    localparam int ACC_W  = WIDTH + $clog2(MAX_OPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NOPS_W-1:0] num_ops,
    output logic              busy,
    input  logic              op_valid,
    input  logic [WIDTH-1:0]  op_data,
    output logic              op_ready,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res_data,
    input  logic              res_ready,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   s_q, s_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic [NOPS_W-1:0]  rem_q, rem_d;
    logic               res_valid_q, res_valid_d;
    logic [ACC_W-1:0]   res_data_q, res_data_d;
    logic               err_q, err_d;

    logic [ACC_W-1:0]   x_ext;
    logic [ACC_W-1:0]   csa_in;
    logic [ACC_W-1:0]   csa_sum;
    logic [ACC_W-1:0]   csa_carry_sh;
    logic               op_xfer;
    logic               start_legal;
    logic               c_zero;

    assign x_ext       = ACC_W'(op_data);
    assign op_xfer     = (state_q == ST_ACCUM) && op_valid;
    assign start_legal = (num_ops != '0) && (num_ops <= NOPS_W'(MAX_OPS));
    assign c_zero      = (c_q == '0);

    // Third CSA input is the operand while accumulating and zero while resolving,
    // so the same bit-slices serve both phases.
    assign csa_in = (state_q == ST_ACCUM) ? x_ext : '0;

    // The carry vector leaves the slices already shifted left by one; the top
    // majority bit is provably zero and is not built.
    assign csa_carry_sh[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < ACC_W; gi++) begin : g_csa_sum
            assign csa_sum[gi] = s_q[gi] ^ c_q[gi] ^ csa_in[gi];
        end
        for (genvar gi = 0; gi < ACC_W - 1; gi++) begin : g_csa_maj
            assign csa_carry_sh[gi+1] = (s_q[gi] & c_q[gi])
                                      | (s_q[gi] & csa_in[gi])
                                      | (c_q[gi] & csa_in[gi]);
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        rem_d       = rem_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_legal) begin
                        rem_d   = num_ops;
                        s_d     = '0;
                        c_d     = '0;
                        err_d   = 1'b0;
                        state_d = ST_ACCUM;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end

            ST_ACCUM: begin
                if (op_xfer) begin
                    s_d   = csa_sum;
                    c_d   = csa_carry_sh;
                    rem_d = rem_q - NOPS_W'(1);
                    if (rem_q == NOPS_W'(1)) begin
                        state_d = ST_RESOLVE;
                    end
                end
            end

            ST_RESOLVE: begin
`ifdef CSA_FAST_RESOLVE_EN
                res_data_d  = s_q + c_q;
                res_valid_d = 1'b1;
                state_d     = ST_DONE;
`else
                if (c_zero) begin
                    res_data_d  = s_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    s_d = csa_sum;
                    c_d = csa_carry_sh;
                end
`endif
            end

            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            c_q         <= '0;
            rem_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            rem_q       <= rem_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign op_ready  = (state_q == ST_ACCUM);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign err       = err_q;

    // c_zero only steers the iterative resolve; keep it referenced in the fast build.
`ifdef CSA_FAST_RESOLVE_EN
    logic c_zero_unused;
    assign c_zero_unused = c_zero;
`endif

endmodule

// File: tb/tb_csa_acc_ctrl.sv
// Directed bench for csa_acc_ctrl: hand-computed results, resolve latency and handshake checks.
module tb_csa_acc_ctrl;

    localparam int WIDTH   = 4;
    localparam int MAX_OPS = 16;
    localparam int NOPS_W  = 5;
    localparam int ACC_W   = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NOPS_W-1:0] num_ops = '0;
    logic              busy;
    logic              op_valid = 1'b0;
    logic [WIDTH-1:0]  op_data = '0;
    logic              op_ready;
    logic              res_valid;
    logic [ACC_W-1:0]  res_data;
    logic              res_ready = 1'b0;
    logic              err;

    csa_acc_ctrl #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_ops   (num_ops),
        .busy      (busy),
        .op_valid  (op_valid),
        .op_data   (op_data),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [WIDTH-1:0] ops [0:15];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand and returns just after the edge that transferred it.
    task automatic send_op(input logic [WIDTH-1:0] x);
        int guard = 0;
        op_valid = 1'b1;
        op_data  = x;
        while (!op_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!op_ready) check_val("op_ready_timeout", 32'd0, 32'd1);
        tick();
        op_valid = 1'b0;
        op_data  = '0;
    endtask

    // Counts edges after the last transfer until res_valid is seen.
    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        while (!res_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_val({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_val({tag, "_valid_after_hs"}, 32'(res_valid), 32'd0);
        check_val({tag, "_busy_after_hs"}, 32'(busy), 32'd0);
    endtask

    task automatic run_job(input string tag, input int n, input bit gaps,
                           input logic [ACC_W-1:0] exp, input bit do_hs, output int lat);
        start   = 1'b1;
        num_ops = n[NOPS_W-1:0];
        tick();
        start   = 1'b0;
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_op_ready"}, 32'(op_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            send_op(ops[i]);
        end
        wait_result(tag, lat);
        check_val({tag, "_res_data"}, 32'(res_data), 32'(exp));
        if (do_hs) handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int sum;

        // Reset state
        tick();
        tick();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_op_ready", 32'(op_ready), 32'd0);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        check_val("rst_res_data", 32'(res_data), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single operand, C stays zero, one-cycle resolve
        ops[0] = 4'b1011;
        run_job("t1", 1, 1'b0, 8'd11, 1'b1, lat);
        check_val("t1_latency", 32'(lat), 32'd1);

        // 2: three operands, internal redundant pair after op2 and op3
        start   = 1'b1;
        num_ops = 5'd3;
        tick();
        start   = 1'b0;
        send_op(4'b1011);
        send_op(4'b0010);
        check_val("t2_s_after_op2", 32'(dut.s_q), 32'h09);
        check_val("t2_c_after_op2", 32'(dut.c_q), 32'h04);
        send_op(4'b0010);
        check_val("t2_s_after_op3", 32'(dut.s_q), 32'h0F);
        check_val("t2_c_after_op3", 32'(dut.c_q), 32'h00);
        wait_result("t2", lat);
        check_val("t2_res_data", 32'(res_data), 32'd15);
        handshake("t2");

        // 3: sixteen all-ones operands with valid gaps
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            ops[i] = 4'hF;
            sum += 15;
        end
        run_job("t3", 16, 1'b1, sum[ACC_W-1:0], 1'b1, lat);
        check_val("t3_expected_f0", 32'(sum), 32'hF0);
`ifdef CSA_FAST_RESOLVE_EN
        check_val("t3_latency", 32'(lat), 32'd1);
`else
        check_val("t3_latency_le9", 32'(lat <= 9 && lat >= 1), 32'd1);
`endif

        // 4: carry ripple F + 1
        ops[0] = 4'hF;
        ops[1] = 4'h1;
        run_job("t4", 2, 1'b0, 8'h10, 1'b1, lat);
`ifdef CSA_FAST_RESOLVE_EN
        check_val("t4_latency", 32'(lat), 32'd1);
`else
        check_val("t4_latency", 32'(lat), 32'd5);
`endif

        // 5: result backpressure with start and op_valid held
        ops[0] = 4'h7;
        ops[1] = 4'h6;
        run_job("t5", 2, 1'b0, 8'd13, 1'b0, lat);
        start    = 1'b1;
        num_ops  = 5'd1;
        op_valid = 1'b1;
        op_data  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("t5_hold_valid", 32'(res_valid), 32'd1);
            check_val("t5_hold_data", 32'(res_data), 32'd13);
            check_val("t5_hold_busy", 32'(busy), 32'd1);
            check_val("t5_hold_op_ready", 32'(op_ready), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        start     = 1'b0;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        check_val("t5_hs_valid", 32'(res_valid), 32'd0);
        check_val("t5_hs_busy", 32'(busy), 32'd0);
        check_val("t5_hs_data_kept", 32'(res_data), 32'd13);
        tick();
        check_val("t5_no_start_taken", 32'(busy), 32'd0);

        // 6: illegal counts, sticky err, clear on legal start, async reset mid-job
        start   = 1'b1;
        num_ops = 5'd0;
        tick();
        check_val("t6_err_zero", 32'(err), 32'd1);
        check_val("t6_busy_zero", 32'(busy), 32'd0);
        check_val("t6_op_ready_zero", 32'(op_ready), 32'd0);
        num_ops = 5'd17;
        tick();
        start   = 1'b0;
        check_val("t6_err_17", 32'(err), 32'd1);
        check_val("t6_busy_17", 32'(busy), 32'd0);
        tick();
        check_val("t6_err_sticky", 32'(err), 32'd1);
        start   = 1'b1;
        num_ops = 5'd4;
        tick();
        start   = 1'b0;
        check_val("t6_err_cleared", 32'(err), 32'd0);
        check_val("t6_busy_legal", 32'(busy), 32'd1);
        send_op(4'h3);
        send_op(4'h5);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        check_val("t6_rst_op_ready", 32'(op_ready), 32'd0);
        check_val("t6_rst_res_valid", 32'(res_valid), 32'd0);
        check_val("t6_rst_res_data", 32'(res_data), 32'd0);
        check_val("t6_rst_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        ops[0] = 4'h7;
        run_job("t6_after_rst", 1, 1'b0, 8'd7, 1'b1, lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
